pipe_ctrl: RTL and testbench

- Parametrised pipeline-register and hazard controller for the riscv32i core.
- Replaces hard-coded pipeReg0..3 shifting with STAGES valid-tagged payload registers.
- Adds load-use stall with bubble insertion, branch/jump flush, external memory stall, operand forwarding selects and retire/perf counters.
- Sits between fetch/decode (input side) and writeback (retire side); execute reads stage 1.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_fwd_sel.sv | 39 +++
 rtl/pipe_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared stage indices, sideband flags and forward-select
// constants for the pipeline register / hazard controller.
package pipe_pkg;

    localparam int ST_IF     = 0;
    localparam int ST_EX     = 1;
    localparam int ST_FWD_LO = ST_EX + 1;
    localparam int FWD_NONE  = 0;

    typedef struct packed {
        logic wr_rd;
        logic is_load;
    } sb_flags_t;

    function automatic int st_mem(input int stages);
        return stages - 2;
    endfunction

    function automatic int st_wb(input int stages);
        return stages - 1;
    endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Forward-select priority encoder: picks the youngest producer
// stage whose destination matches the stage-1 source register.
module pipe_fwd_sel
    import pipe_pkg::*;
#(
    parameter int NCAND  = 2,
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2
) (
    input  logic [REG_AW-1:0]             i_rs,
    input  logic [NCAND-1:0]              i_valid,
    input  logic [NCAND-1:0]              i_wr,
    input  logic [NCAND-1:0][REG_AW-1:0]  i_rd,
    output logic [SEL_W-1:0]              o_sel
);

    logic [NCAND-1:0] w_hit;

    always_comb begin
        w_hit = '0;
        for (int c = 0; c < NCAND; c++) begin
            w_hit[c] = i_valid[c] && i_wr[c] &&
                       (i_rd[c] != '0) && (i_rd[c] == i_rs);
        end
    end

    // Scan oldest to youngest so the lowest stage index wins.
    always_comb begin
        o_sel = SEL_W'(FWD_NONE);
        if (i_rs != '0) begin
            for (int c = NCAND - 1; c >= 0; c--) begin
                if (w_hit[c]) begin
                    o_sel = SEL_W'(c + ST_FWD_LO);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Valid-tagged pipeline registers with load-use stall, flush,
// memory stall, operand forwarding selects and perf counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int STAGES      = 4,
    parameter int PAYLOAD_W   = 352,
    parameter int REG_AW      = 5,
    parameter int FLUSH_STAGE = 2,
    parameter int SEL_W       = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PAYLOAD_W-1:0]          in_payload,
    input  logic [REG_AW-1:0]             in_rd,
    input  logic [REG_AW-1:0]             in_rs1,
    input  logic [REG_AW-1:0]             in_rs2,
    input  logic                          in_wr_rd,
    input  logic                          in_is_load,
    input  logic [STAGES*PAYLOAD_W-1:0]   upd_payload,
    input  logic                          flush,
    input  logic                          mem_stall,
    output logic [STAGES-1:0]             stage_valid,
    output logic [STAGES*PAYLOAD_W-1:0]   stage_payload,
    output logic [SEL_W-1:0]              fwd_sel_rs1,
    output logic [SEL_W-1:0]              fwd_sel_rs2,
    output logic                          hazard_stall,
    output logic                          retire_valid,
    output logic [31:0]                   stall_cnt,
    output logic [31:0]                   flush_cnt,
    output logic [31:0]                   retire_cnt
);

    localparam int ST_MEM = st_mem(STAGES);
    localparam int ST_WB  = st_wb(STAGES);
    localparam int NCAND  = STAGES - ST_FWD_LO;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        sb_flags_t         f;
    } sb_t;

    logic [STAGES-1:0]    r_valid;
    logic [PAYLOAD_W-1:0] r_pay [STAGES];
    sb_t                  r_sb  [STAGES];
    logic [31:0]          r_stall_cnt;
    logic [31:0]          r_flush_cnt;
    logic [31:0]          r_retire_cnt;

    logic [STAGES-1:0]    w_valid;
    logic [PAYLOAD_W-1:0] w_pay [STAGES];
    sb_t                  w_sb  [STAGES];
    sb_t                  w_in_sb;
    logic                 w_lu;
    logic                 w_lu_stall;
    logic                 w_flush;
    logic                 w_accept;
    logic                 w_unused_upd0;

    logic [NCAND-1:0]             w_cand_v;
    logic [NCAND-1:0]             w_cand_wr;
    logic [NCAND-1:0][REG_AW-1:0] w_cand_rd;

    // Stage 0 has no upstream stage, so its update slice is ignored.
    assign w_unused_upd0 = ^upd_payload[PAYLOAD_W-1:0];

    assign w_lu = r_valid[ST_EX] && r_valid[ST_IF] &&
                  r_sb[ST_EX].f.is_load && r_sb[ST_EX].f.wr_rd &&
                  (r_sb[ST_EX].rd != '0) &&
                  ((r_sb[ST_EX].rd == r_sb[ST_IF].rs1) ||
                   (r_sb[ST_EX].rd == r_sb[ST_IF].rs2));

    assign w_flush      = flush && !mem_stall;
    assign w_lu_stall   = w_lu && !flush && !mem_stall;
    assign in_ready     = !mem_stall && !flush && !w_lu;
    assign w_accept     = in_valid && in_ready;
    assign hazard_stall = w_lu_stall;

    always_comb begin
        w_in_sb           = '0;
        w_in_sb.rd        = in_rd;
        w_in_sb.rs1       = in_rs1;
        w_in_sb.rs2       = in_rs2;
        w_in_sb.f.wr_rd   = in_wr_rd;
        w_in_sb.f.is_load = in_is_load;
    end

    always_comb begin
        w_valid = r_valid;
        for (int i = 0; i < STAGES; i++) begin
            w_pay[i] = r_pay[i];
            w_sb[i]  = r_sb[i];
        end
        w_valid[ST_IF] = w_accept;
        if (w_accept) begin
            w_pay[ST_IF] = in_payload;
            w_sb[ST_IF]  = w_in_sb;
        end
        for (int i = 1; i < STAGES; i++) begin
            w_valid[i] = r_valid[i-1];
            w_pay[i]   = upd_payload[i*PAYLOAD_W +: PAYLOAD_W];
            w_sb[i]    = r_sb[i-1];
        end
        // Memory stall freezes everything up to MEM; WB drains.
        if (mem_stall) begin
            for (int i = 0; i <= ST_MEM; i++) begin
                w_valid[i] = r_valid[i];
                w_pay[i]   = r_pay[i];
                w_sb[i]    = r_sb[i];
            end
            w_valid[ST_WB] = 1'b0;
        end else if (flush) begin
            for (int i = 0; i < FLUSH_STAGE; i++) begin
                w_valid[i] = 1'b0;
            end
        end else if (w_lu) begin
            w_valid[ST_IF] = r_valid[ST_IF];
            w_pay[ST_IF]   = r_pay[ST_IF];
            w_sb[ST_IF]    = r_sb[ST_IF];
            w_valid[ST_EX] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_pay[i] <= '0;
                r_sb[i]  <= '0;
            end
        end else begin
            r_valid <= w_valid;
            for (int i = 0; i < STAGES; i++) begin
                r_pay[i] <= w_pay[i];
                r_sb[i]  <= w_sb[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (mem_stall || w_lu_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_flush) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
            if (r_valid[ST_WB]) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_out
        assign stage_payload[g*PAYLOAD_W +: PAYLOAD_W] = r_pay[g];
    end

    for (genvar c = 0; c < NCAND; c++) begin : g_cand
        assign w_cand_v[c]  = r_valid[c + ST_FWD_LO];
        assign w_cand_wr[c] = r_sb[c + ST_FWD_LO].f.wr_rd;
        assign w_cand_rd[c] = r_sb[c + ST_FWD_LO].rd;
    end

    pipe_fwd_sel #(
        .NCAND  (NCAND),
        .REG_AW (REG_AW),
        .SEL_W  (SEL_W)
    ) u_fwd_rs1 (
        .i_rs    (r_sb[ST_EX].rs1),
        .i_valid (w_cand_v),
        .i_wr    (w_cand_wr),
        .i_rd    (w_cand_rd),
        .o_sel   (fwd_sel_rs1)
    );

    pipe_fwd_sel #(
        .NCAND  (NCAND),
        .REG_AW (REG_AW),
        .SEL_W  (SEL_W)
    ) u_fwd_rs2 (
        .i_rs    (r_sb[ST_EX].rs2),
        .i_valid (w_cand_v),
        .i_wr    (w_cand_wr),
        .i_rd    (w_cand_rd),
        .o_sel   (fwd_sel_rs2)
    );

    assign stage_valid  = r_valid;
    assign retire_valid = r_valid[ST_WB];
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;
    assign retire_cnt   = r_retire_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, forwarding, load-use,
// flush, memory stall and retire counting.
module tb_pipe_ctrl;

    localparam int STAGES = 4;
    localparam int PW     = 352;
    localparam int AW     = 5;
    localparam int SW     = 2;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [PW-1:0]         in_payload = '0;
    logic [AW-1:0]         in_rd = '0;
    logic [AW-1:0]         in_rs1 = '0;
    logic [AW-1:0]         in_rs2 = '0;
    logic                  in_wr_rd = 1'b0;
    logic                  in_is_load = 1'b0;
    logic [STAGES*PW-1:0]  upd_payload;
    logic                  flush = 1'b0;
    logic                  mem_stall = 1'b0;
    logic [STAGES-1:0]     stage_valid;
    logic [STAGES*PW-1:0]  stage_payload;
    logic [SW-1:0]         fwd_sel_rs1;
    logic [SW-1:0]         fwd_sel_rs2;
    logic                  hazard_stall;
    logic                  retire_valid;
    logic [31:0]           stall_cnt;
    logic [31:0]           flush_cnt;
    logic [31:0]           retire_cnt;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    // Execute/memory model: each stage adds its index to the payload.
    always_comb begin
        upd_payload = '0;
        for (int i = 1; i < STAGES; i++) begin
            upd_payload[i*PW +: PW] =
                stage_payload[(i-1)*PW +: PW] + PW'(i);
        end
    end

    pipe_ctrl #(
        .STAGES      (STAGES),
        .PAYLOAD_W   (PW),
        .REG_AW      (AW),
        .FLUSH_STAGE (2),
        .SEL_W       (SW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_payload    (in_payload),
        .in_rd         (in_rd),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_wr_rd      (in_wr_rd),
        .in_is_load    (in_is_load),
        .upd_payload   (upd_payload),
        .flush         (flush),
        .mem_stall     (mem_stall),
        .stage_valid   (stage_valid),
        .stage_payload (stage_payload),
        .fwd_sel_rs1   (fwd_sel_rs1),
        .fwd_sel_rs2   (fwd_sel_rs2),
        .hazard_stall  (hazard_stall),
        .retire_valid  (retire_valid),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
        .retire_cnt    (retire_cnt)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] pl(input int k);
        return stage_payload[k*PW +: 32];
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] pay,
                         input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2,
                         input logic wr,
                         input logic ld);
        in_valid   = 1'b1;
        in_payload = PW'(pay);
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_wr_rd   = wr;
        in_is_load = ld;
        cyc();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        cyc();
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_valid", 64'(stage_valid), 64'h0);
        chk("rst_ready", 64'(in_ready), 64'h1);
        chk("rst_hazard", 64'(hazard_stall), 64'h0);
        chk("rst_retire", 64'(retire_valid), 64'h0);
        chk("rst_fwd", 64'({fwd_sel_rs1, fwd_sel_rs2}), 64'h0);
        chk("rst_cnt", {32'(stall_cnt | flush_cnt), retire_cnt}, 64'h0);
        reset = 1'b1;

        // Mid-stream asynchronous reset
        issue(32'd100, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        issue(32'd110, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        issue(32'd120, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("fill_valid", 64'(stage_valid), 64'h7);
        chk("fill_pay2", 64'(pl(2)), 64'd103);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_valid", 64'(stage_valid), 64'h0);
        chk("async_pay2", 64'(pl(2)), 64'h0);
        @(negedge clk);
        reset = 1'b1;

        // Forwarding: back-to-back, 3-ago, youngest priority
        issue(32'd10, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0);
        issue(32'd11, 5'd2, 5'd1, 5'd1, 1'b1, 1'b0);
        issue(32'd12, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0);
        chk("fwd_b2b", 64'({fwd_sel_rs1, fwd_sel_rs2}), 64'ha);
        chk("fwd_b2b_hz", 64'(hazard_stall), 64'h0);
        issue(32'd13, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("fwd_none", 64'({fwd_sel_rs1, fwd_sel_rs2}), 64'h0);
        issue(32'd14, 5'd4, 5'd3, 5'd0, 1'b1, 1'b0);
        idle();
        chk("fwd_3ago", 64'({fwd_sel_rs1, fwd_sel_rs2}), 64'hc);
        issue(32'd15, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0);
        issue(32'd16, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0);
        issue(32'd17, 5'd8, 5'd7, 5'd7, 1'b1, 1'b0);
        idle();
        chk("fwd_young", 64'({fwd_sel_rs1, fwd_sel_rs2}), 64'ha);
        idle();
        idle();
        idle();
        chk("drain_c", 64'(stage_valid), 64'h0);

        // Load-use: lw x5 ; add x6,x5,x0
        issue(32'd200, 5'd5, 5'd10, 5'd0, 1'b1, 1'b1);
        issue(32'd210, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0);
        in_valid = 1'b0;
        chk("lu_hazard", 64'(hazard_stall), 64'h1);
        chk("lu_ready", 64'(in_ready), 64'h0);
        cyc();
        chk("lu_bubble", 64'(stage_valid), 64'h5);
        chk("lu_stallcnt", 64'(stall_cnt), 64'd1);
        chk("lu_pay2", 64'(pl(2)), 64'd203);
        cyc();
        chk("lu_fwd", 64'({fwd_sel_rs1, fwd_sel_rs2}), 64'hc);
        chk("lu_pay3", 64'(pl(3)), 64'd206);
        chk("lu_after", 64'(stage_valid), 64'ha);
        idle();
        idle();
        idle();

        // Memory stall over a pending flush
        issue(32'd400, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        issue(32'd410, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        issue(32'd300, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
        issue(32'd420, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("ms_full", 64'(stage_valid), 64'hf);
        in_valid   = 1'b1;
        in_payload = PW'(32'd430);
        flush      = 1'b1;
        mem_stall  = 1'b1;
        #1;
        chk("ms_ready", 64'(in_ready), 64'h0);
        cyc();
        chk("ms_wb_bub", 64'(stage_valid), 64'h7);
        chk("ms_pay1", 64'(pl(1)), 64'd301);
        cyc();
        cyc();
        chk("ms_frozen", 64'(stage_valid), 64'h7);
        chk("ms_stallcnt", 64'(stall_cnt), 64'd4);
        chk("ms_noflush", 64'(flush_cnt), 64'd0);
        mem_stall = 1'b0;
        #1;
        chk("fl_ready", 64'(in_ready), 64'h0);
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 64'(stage_valid), 64'hc);
        chk("fl_pay2", 64'(pl(2)), 64'd303);
        chk("fl_cnt", 64'(flush_cnt), 64'd1);
        chk("fl_stallcnt", 64'(stall_cnt), 64'd4);

        // Reset clears nonzero counters at once
        #2 reset = 1'b0;
        #1;
        chk("rst2_valid", 64'(stage_valid), 64'h0);
        chk("rst2_cnt", {32'(stall_cnt | flush_cnt), retire_cnt}, 64'h0);
        @(negedge clk);
        reset = 1'b1;

        // x0 write/use, then ten instructions retire
        issue(32'd500, 5'd0, 5'd10, 5'd0, 1'b1, 1'b1);
        issue(32'd501, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0);
        chk("x0_hazard", 64'(hazard_stall), 64'h0);
        chk("x0_ready", 64'(in_ready), 64'h1);
        issue(32'd502, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("x0_fwd", 64'({fwd_sel_rs1, fwd_sel_rs2}), 64'h0);
        for (int i = 3; i < 10; i++) begin
            issue(32'd500 + 32'(i), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        end
        idle();
        idle();
        idle();
        chk("ret_last", 64'(retire_valid), 64'h1);
        idle();
        chk("ret_cnt", 64'(retire_cnt), 64'd10);
        chk("ret_done", 64'(retire_valid), 64'h0);
        chk("ret_stall", 64'(stall_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
